// File: rtl/sys_ctrl_tx_q.sv
// sys_ctrl_tx_q: queues ALU results and register reads, then serializes them LSB-first to a UART TX.
// Optional build macro CTRL_TX_TAG_EN prefixes each entry with a tag byte (A1 = ALU, B2 = RdData).
module sys_ctrl_tx_q #(
    parameter int ALU_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [ALU_W-1:0] ALU_OUT,
    input  logic             OUT_Valid,
    input  logic [7:0]       RdData,
    input  logic             RdData_Valid,
    input  logic             Busy,
    output logic [7:0]       TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             Q_Full,
    output logic [7:0]       Drop_Cnt
);
    // state | meaning
    // IDLE  | waiting for a queued entry and Busy low
    // TAG   | emit tag byte (CTRL_TX_TAG_EN only)
    // SEND  | emit the low byte of the shift register
    // ACK   | wait for UART to raise Busy
    // DONE  | wait for Busy low, then next byte or back to IDLE
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [2:0]  ALU_BYTES = 3'(ALU_W / 8);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        ACK  = 3'd2,
        DONE = 3'd3
`ifdef CTRL_TX_TAG_EN
        , TAG = 3'd4
`endif
    } state_t;

    logic [ALU_W:0]   mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, rd_slot;
    logic [AW:0]      occ_q, occ_d, free_w;
    logic             q_full_q;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       drop_sum;
    logic             push_alu, push_rd, pop;
    logic [1:0]       n_push, n_drop;
    state_t           state_q, state_d;
    logic [2:0]       bytes_q, bytes_d;
    logic [ALU_W-1:0] shift_q, shift_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;
    logic [ALU_W:0]   head;
`ifdef CTRL_TX_TAG_EN
    logic             typ_q, typ_d, tagph_q, tagph_d;
`endif

    // Free slots are judged on the occupancy before this cycle's pop.
    assign free_w   = DEPTH_C - occ_q;
    assign push_alu = OUT_Valid && (free_w != '0);
    assign push_rd  = RdData_Valid && (OUT_Valid ? (free_w >= (AW+1)'(2)) : (free_w != '0));
    assign n_push   = {1'b0, push_alu} + {1'b0, push_rd};
    assign n_drop   = ({1'b0, OUT_Valid} + {1'b0, RdData_Valid}) - n_push;
    assign pop      = (state_q == IDLE) && (occ_q != '0) && !Busy;
    assign occ_d    = occ_q + (AW+1)'(n_push) - (AW+1)'(pop);
    assign wptr_d   = wptr_q + AW'(n_push);
    assign rptr_d   = rptr_q + AW'(pop);
    assign rd_slot  = push_alu ? wptr_q + AW'(1) : wptr_q;
    assign drop_sum = {1'b0, drop_q} + 9'(n_drop);
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    assign head     = mem_q[rptr_q];

    always_ff @(posedge CLK) begin
        if (push_alu) mem_q[wptr_q]  <= {1'b0, ALU_OUT};
        if (push_rd)  mem_q[rd_slot] <= {1'b1, {(ALU_W-8){1'b0}}, RdData};
    end

    always_comb begin
        state_d   = state_q;
        bytes_d   = bytes_q;
        shift_d   = shift_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
`ifdef CTRL_TX_TAG_EN
        typ_d     = typ_q;
        tagph_d   = tagph_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = head[ALU_W-1:0];
                    bytes_d = head[ALU_W] ? 3'd1 : ALU_BYTES;
`ifdef CTRL_TX_TAG_EN
                    typ_d   = head[ALU_W];
                    state_d = TAG;
`else
                    state_d = SEND;
`endif
                end
            end
`ifdef CTRL_TX_TAG_EN
            TAG: begin
                tx_data_d = typ_q ? 8'hB2 : 8'hA1;
                tx_vld_d  = 1'b1;
                tagph_d   = 1'b1;
                state_d   = ACK;
            end
`endif
            SEND: begin
                tx_data_d = shift_q[7:0];
                tx_vld_d  = 1'b1;
                state_d   = ACK;
            end
            ACK: begin
                if (Busy) state_d = DONE;
            end
            DONE: begin
                if (!Busy) begin
`ifdef CTRL_TX_TAG_EN
                    if (tagph_q) begin
                        tagph_d = 1'b0;
                        state_d = SEND;
                    end else
`endif
                    begin
                        bytes_d = bytes_q - 3'd1;
                        shift_d = shift_q >> 8;
                        state_d = (bytes_q == 3'd1) ? IDLE : SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            q_full_q  <= 1'b0;
            drop_q    <= '0;
            state_q   <= IDLE;
            bytes_q   <= '0;
            shift_q   <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
`ifdef CTRL_TX_TAG_EN
            typ_q     <= 1'b0;
            tagph_q   <= 1'b0;
`endif
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            q_full_q  <= (occ_d == DEPTH_C);
            drop_q    <= drop_d;
            state_q   <= state_d;
            bytes_q   <= bytes_d;
            shift_q   <= shift_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
`ifdef CTRL_TX_TAG_EN
            typ_q     <= typ_d;
            tagph_q   <= tagph_d;
`endif
        end
    end

    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign Q_Full    = q_full_q;
    assign Drop_Cnt  = drop_q;
endmodule
